strbuf_responder: RTL and testbench

- Store-buffer responder on the strBuf side of the prefetcher's memory interface.
- Accepts prefetcher writes (w_addr/w_data) into a FIFO and drains them in order to backing memory.
- Serves prefetcher reads (strBuf_data_req/strBuf_r_addr) from the youngest matching buffered entry, or from backing memory on a miss.
- Answers with wait_strBuf / strBuf_data_ready / strBuf_data.

---
 rtl/strbuf_responder.sv | 165 ++++++++++++++++
 tb/tb_strbuf_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strbuf_responder.sv
// strbuf_responder: store buffer between the prefetcher and backing memory.
// Writes are queued in a small FIFO and drained to memory in arrival order.
// Reads are served from the youngest buffered copy of an address, or fetched
// from memory when no buffered entry holds that address.
//
// Read FSM states:
//   state    | meaning
//   S_IDLE   | waiting for strBuf_data_req, address latched on request
//   S_LOOKUP | compare latched address against all valid buffer entries
//   S_MEM    | miss: mem_r_req held until mem_r_valid
//   S_RESP   | one-cycle strBuf_data_ready pulse with captured data
module strbuf_responder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_en,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    output logic        w_full,
    input  logic        strBuf_data_req,
    input  logic [31:0] strBuf_r_addr,
    output logic        wait_strBuf,
    output logic        strBuf_data_ready,
    output logic [31:0] strBuf_data,
    output logic        mem_w_req,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    input  logic        mem_w_ack,
    output logic        mem_r_req,
    output logic [31:0] mem_r_addr,
    input  logic        mem_r_valid,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM, S_RESP} rd_state_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [31:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop;

    rd_state_t        rd_state;
    logic [31:0]      rd_addr;
    logic             hit;
    logic [31:0]      hit_data;
    logic [PTR_W-1:0] idx;

    assign push       = w_en & ~w_full;
    assign pop        = mem_w_req & mem_w_ack;
    assign mem_w_req  = (count != '0);
    // Head entry is only meaningful while something is buffered; show 0 otherwise.
    assign mem_w_addr = mem_w_req ? ent_addr[head] : '0;
    assign mem_w_data = mem_w_req ? ent_data[head] : '0;
    assign mem_r_addr = rd_addr;

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // Payload storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= w_addr;
            ent_data[tail] <= w_data;
        end
    end

    // FIFO pointers, valid bits and the registered full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            w_full    <= 1'b0;
        end else begin
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            count  <= count_nxt;
            w_full <= (count_nxt == FULL_CNT);
        end
    end

    // Walk oldest to youngest so the last match found is the youngest copy.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (ent_valid[idx] && (ent_addr[idx] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

    // Read FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state          <= S_IDLE;
            rd_addr           <= '0;
            wait_strBuf       <= 1'b0;
            strBuf_data_ready <= 1'b0;
            strBuf_data       <= '0;
            mem_r_req         <= 1'b0;
        end else begin
            case (rd_state)
                S_IDLE: begin
                    if (strBuf_data_req) begin
                        rd_addr     <= strBuf_r_addr;
                        wait_strBuf <= 1'b1;
                        rd_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        strBuf_data       <= hit_data;
                        strBuf_data_ready <= 1'b1;
                        wait_strBuf       <= 1'b0;
                        rd_state          <= S_RESP;
                    end else begin
                        mem_r_req <= 1'b1;
                        rd_state  <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_r_valid) begin
                        strBuf_data       <= mem_r_data;
                        strBuf_data_ready <= 1'b1;
                        wait_strBuf       <= 1'b0;
                        mem_r_req         <= 1'b0;
                        rd_state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    strBuf_data_ready <= 1'b0;
                    rd_state          <= S_IDLE;
                end
                default: rd_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strbuf_responder.sv
// Bench for strbuf_responder: directed literal scenarios plus randomized traffic,
// all checked against a queue-based model of the buffer and read transaction.
module tb_strbuf_responder;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_full;
    logic        strBuf_data_req;
    logic [31:0] strBuf_r_addr;
    logic        wait_strBuf;
    logic        strBuf_data_ready;
    logic [31:0] strBuf_data;
    logic        mem_w_req;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic        mem_w_ack;
    logic        mem_r_req;
    logic [31:0] mem_r_addr;
    logic        mem_r_valid;
    logic [31:0] mem_r_data;

    strbuf_responder #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .w_en              (w_en),
        .w_addr            (w_addr),
        .w_data            (w_data),
        .w_full            (w_full),
        .strBuf_data_req   (strBuf_data_req),
        .strBuf_r_addr     (strBuf_r_addr),
        .wait_strBuf       (wait_strBuf),
        .strBuf_data_ready (strBuf_data_ready),
        .strBuf_data       (strBuf_data),
        .mem_w_req         (mem_w_req),
        .mem_w_addr        (mem_w_addr),
        .mem_w_data        (mem_w_data),
        .mem_w_ack         (mem_w_ack),
        .mem_r_req         (mem_r_req),
        .mem_r_addr        (mem_r_addr),
        .mem_r_valid       (mem_r_valid),
        .mem_r_data        (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_phase;   // 0 idle, 1 lookup, 2 waiting on memory, 3 responding
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_raddr = '0;
        m_rdata = '0;
    endtask

    // Applied at each active edge using the inputs in force at that edge.
    task automatic model_step();
        bit   do_push;
        bit   do_pop;
        bit   found;
        ent_t e;
        do_push = w_en && (mq.size() < DEPTH);
        do_pop  = mem_w_ack && (mq.size() > 0);
        case (m_phase)
            0: if (strBuf_data_req) begin
                   m_raddr = strBuf_r_addr;
                   m_phase = 1;
               end
            1: begin
                   found = 0;
                   for (int i = mq.size() - 1; i >= 0; i--) begin
                       if (!found && mq[i].a == m_raddr) begin
                           found   = 1;
                           m_rdata = mq[i].d;
                       end
                   end
                   m_phase = found ? 3 : 2;
               end
            2: if (mem_r_valid) begin
                   m_rdata = mem_r_data;
                   m_phase = 3;
               end
            default: m_phase = 0;
        endcase
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.a = w_addr;
            e.d = w_data;
            mq.push_back(e);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk1("w_full", w_full, mq.size() == DEPTH);
        chk1("mem_w_req", mem_w_req, mq.size() > 0);
        if (mq.size() > 0) begin
            chk32("mem_w_addr", mem_w_addr, mq[0].a);
            chk32("mem_w_data", mem_w_data, mq[0].d);
        end
        chk1("wait_strBuf", wait_strBuf, (m_phase == 1) || (m_phase == 2));
        chk1("strBuf_data_ready", strBuf_data_ready, m_phase == 3);
        chk32("strBuf_data", strBuf_data, m_rdata);
        chk1("mem_r_req", mem_r_req, m_phase == 2);
        if (m_phase == 2)
            chk32("mem_r_addr", mem_r_addr, m_raddr);
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic set_idle();
        w_en            = 1'b0;
        w_addr          = '0;
        w_data          = '0;
        strBuf_data_req = 1'b0;
        strBuf_r_addr   = '0;
        mem_w_ack       = 1'b0;
        mem_r_valid     = 1'b0;
        mem_r_data      = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_w_full"}, w_full, 1'b0);
        chk1({tag, "_mem_w_req"}, mem_w_req, 1'b0);
        chk32({tag, "_mem_w_addr"}, mem_w_addr, 32'h0);
        chk32({tag, "_mem_w_data"}, mem_w_data, 32'h0);
        chk1({tag, "_wait"}, wait_strBuf, 1'b0);
        chk1({tag, "_ready"}, strBuf_data_ready, 1'b0);
        chk32({tag, "_data"}, strBuf_data, 32'h0);
        chk1({tag, "_mem_r_req"}, mem_r_req, 1'b0);
        chk32({tag, "_mem_r_addr"}, mem_r_addr, 32'h0);
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released.
    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic write_one(input logic [31:0] a, input logic [31:0] d);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        tick();
        w_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Hit with fixed two-cycle latency
        do_reset();
        write_one(32'h100, 32'hAAAA_0001);
        strBuf_data_req = 1'b1;
        strBuf_r_addr   = 32'h100;
        tick();
        strBuf_data_req = 1'b0;
        chk1("hit_wait_c1", wait_strBuf, 1'b1);
        chk1("hit_ready_c1", strBuf_data_ready, 1'b0);
        chk1("hit_no_rreq_c1", mem_r_req, 1'b0);
        tick();
        chk1("hit_ready_c2", strBuf_data_ready, 1'b1);
        chk32("hit_data_c2", strBuf_data, 32'hAAAA_0001);
        chk1("hit_wait_c2", wait_strBuf, 1'b0);
        chk1("hit_no_rreq_c2", mem_r_req, 1'b0);
        tick();
        chk1("hit_ready_c3", strBuf_data_ready, 1'b0);
        chk32("hit_data_held", strBuf_data, 32'hAAAA_0001);

        // Youngest matching entry wins
        do_reset();
        write_one(32'h200, 32'h1);
        write_one(32'h200, 32'h2);
        strBuf_data_req = 1'b1;
        strBuf_r_addr   = 32'h200;
        tick();
        strBuf_data_req = 1'b0;
        tick();
        chk1("young_ready", strBuf_data_ready, 1'b1);
        chk32("young_data", strBuf_data, 32'h2);

        // Miss served from memory, mem_r_req held three cycles
        do_reset();
        strBuf_data_req = 1'b1;
        strBuf_r_addr   = 32'h300;
        tick();
        strBuf_data_req = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk1("miss_rreq", mem_r_req, 1'b1);
            chk32("miss_raddr", mem_r_addr, 32'h300);
            chk1("miss_wait", wait_strBuf, 1'b1);
            chk1("miss_no_ready", strBuf_data_ready, 1'b0);
            if (k == 2) begin
                mem_r_valid = 1'b1;
                mem_r_data  = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_r_valid = 1'b0;
        chk1("miss_rreq_drop", mem_r_req, 1'b0);
        chk1("miss_ready", strBuf_data_ready, 1'b1);
        chk32("miss_data", strBuf_data, 32'hDEAD_BEEF);
        tick();
        chk1("miss_ready_once", strBuf_data_ready, 1'b0);

        // Full, ignored ninth write, wrap, ordered drain
        do_reset();
        for (int i = 0; i < 9; i++) begin
            write_one(32'h1000 + 32'(i * 4), 32'(i));
            chk1("fill_w_full", w_full, i >= 7);
        end
        mem_w_ack = 1'b1;
        tick();
        mem_w_ack = 1'b0;
        chk1("after_ack_not_full", w_full, 1'b0);
        write_one(32'h2000, 32'h2000_0000);
        chk1("refill_full", w_full, 1'b1);
        mem_w_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk1("drain_req", mem_w_req, 1'b1);
            chk32("drain_addr", mem_w_addr, (k < 7) ? 32'h1004 + 32'(k * 4) : 32'h2000);
            tick();
        end
        mem_w_ack = 1'b0;
        chk1("drain_empty", mem_w_req, 1'b0);

        // Enqueue and pop together keep occupancy at three
        do_reset();
        for (int i = 0; i < 3; i++) write_one(32'h600 + 32'(i * 4), 32'h60 + 32'(i));
        w_en      = 1'b1;
        w_addr    = 32'h60C;
        w_data    = 32'h63;
        mem_w_ack = 1'b1;
        tick();
        w_en      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("simul_req", mem_w_req, 1'b1);
            chk32("simul_addr", mem_w_addr, 32'h604 + 32'(k * 4));
            tick();
        end
        mem_w_ack = 1'b0;
        chk1("simul_empty", mem_w_req, 1'b0);

        // Read hit while draining
        do_reset();
        write_one(32'h400, 32'h44);
        write_one(32'h404, 32'h55);
        mem_w_ack       = 1'b1;
        strBuf_data_req = 1'b1;
        strBuf_r_addr   = 32'h404;
        chk32("rd_drain_head0", mem_w_addr, 32'h400);
        tick();
        strBuf_data_req = 1'b0;
        chk32("rd_drain_head1", mem_w_addr, 32'h404);
        chk1("rd_drain_wait", wait_strBuf, 1'b1);
        tick();
        mem_w_ack = 1'b0;
        chk1("rd_drain_ready", strBuf_data_ready, 1'b1);
        chk32("rd_drain_data", strBuf_data, 32'h55);
        chk1("rd_drain_empty", mem_w_req, 1'b0);

        // Reset asserted while waiting on memory
        do_reset();
        strBuf_data_req = 1'b1;
        strBuf_r_addr   = 32'h500;
        tick();
        strBuf_data_req = 1'b0;
        tick();
        chk1("midmiss_rreq", mem_r_req, 1'b1);
        reset = 1'b0;
        model_reset();
        #1 check_all_zero("midmiss_rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        mem_r_valid = 1'b1;
        mem_r_data  = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("midmiss_no_ready", strBuf_data_ready, 1'b0);
            chk1("midmiss_empty", mem_w_req, 1'b0);
        end
        mem_r_valid = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            w_en            = ($urandom_range(0, 1) == 0);
            w_addr          = 32'h800 + 32'($urandom_range(0, 7) * 4);
            w_data          = $urandom;
            mem_w_ack       = ($urandom_range(0, 4) < 2);
            strBuf_data_req = ($urandom_range(0, 2) == 0);
            strBuf_r_addr   = 32'h800 + 32'($urandom_range(0, 9) * 4);
            mem_r_valid     = ($urandom_range(0, 3) == 0);
            mem_r_data      = $urandom;
            tick();
        end
        set_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
